sprite_line_scheduler: RTL and testbench
========================================

# sprite_line_scheduler

Per-scanline sprite scheduler for the GPU pipeline. Holds a sprite attribute table, scans it during horizontal blanking to select up to `NUM_SLOTS` 16×16 sprites that intersect the upcoming line, and then resolves, per pixel, the highest-priority hit into match/tile/offset outputs for the tile fetch stage. It sequences a shared bank of per-line matching slots, so the GPU does not need one matcher per sprite.

## Interface
- `NUM_SPRITES`, 16: attribute table entries (power of two).
- `NUM_SLOTS`, 4: sprites displayable per line.
- `IDX_W`, 4: `clog2(NUM_SPRITES)`.
- `gpu_clk`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_we`  in  1  table write strobe (CPU bridge, already in the `gpu_clk` domain).
- `cfg_index`  in  IDX_W  entry to write.
- `cfg_field`  in  1  0 = position word `{y[15:0], x[15:0]}`; 1 = tile word, tile in `[31:16]`.
- `cfg_wdata`  in  32  write data.
- `line_start`  in  1  one-cycle pulse at the start of hblank.
- `next_line`  in  16  line to be scheduled; sampled with `line_start`.
- `pixel`  in  16  current pixel x.
- `scan_busy`  out  1  scan in progress.
- `overflow`  out  1  more than `NUM_SLOTS` sprites hit the last committed line.
- `match`  out  1  the pixel is covered by a scheduled sprite.
- `tile_number`  out  16  tile of the winning sprite.
- `x_offset`  out  8  column in the sprite, 0–15.
- `y_offset`  out  8  row in the sprite, 0–15.

## Operation
- **Table**
  - Each entry holds a position (x, y) and a tile number.
  - Reset values: position 0, tile 16'hFFFF.
  - An entry is valid iff tile ≠ 16'hFFFF.
- **Slots**
  - Two banks of `NUM_SLOTS` slots: shadow and active.
  - Each slot holds `valid`, `x[15:0]`, `tile[15:0]` and `yoff[3:0]`.
  - Reset: all slots invalid.
- **FSM states:** IDLE, SCAN, COMMIT.
  - IDLE + `line_start` → SCAN. Latch `next_line`, clear the shadow bank, entry index = 0, shadow fill count = 0, overflow flag = 0.
  - SCAN examines one entry per cycle. Entry *i* hits iff it is valid and `y ≤ L < y+16`.
    - Compare in 17-bit arithmetic, so there is no wrap: y = 16'hFFF8 never hits L = 3.
    - On a hit with fill count < `NUM_SLOTS`: write the shadow slot at the fill count with `{1, x, tile, (L−y)[3:0]}`, then increment the fill count.
    - On a hit with the shadow bank full: set the overflow flag and drop the entry.
  - After entry `NUM_SPRITES−1`, go to COMMIT.
  - COMMIT: copy shadow → active, register the `overflow` output, return to IDLE.
- **`line_start` in SCAN or COMMIT:** abort and restart SCAN for the new `next_line`. The active bank and `overflow` are left unchanged. An aborted scan never commits.
- **Config write racing the scan**
  - A write to an entry not yet scanned is seen by the scan.
  - A write to the entry being scanned in the same cycle is not seen; the scan uses the pre-write value.
  - Writes never touch slots directly.
- **Pixel resolve**
  - Slot *s* covers the pixel iff `valid[s]` and `x ≤ pixel < x+16`, in 17-bit arithmetic.
  - Lowest slot index wins, which means lowest table index wins.
  - Winner drives:
    - `match` = 1
    - `tile_number` = slot tile
    - `x_offset` = `{4'b0, (pixel−x)[3:0]}`
    - `y_offset` = `{4'b0, yoff}`
  - No winner drives `match` = 0, `tile_number` = 16'hFFFF, offsets = 0.

## Timing
- **Reset values:** `match` 0, `tile_number` 16'hFFFF, `x_offset` 0, `y_offset` 0, `scan_busy` 0, `overflow` 0. FSM in IDLE.
- **Scan sequence**, with `line_start` in cycle t:
  - SCAN covers cycles t+1 … t+`NUM_SPRITES`.
  - COMMIT is cycle t+`NUM_SPRITES`+1.
  - Active bank and `overflow` take their new values at the end of COMMIT, so they are visible from cycle t+`NUM_SPRITES`+2.
- **`scan_busy`:** registered; high from t+1 through COMMIT, i.e. for `NUM_SPRITES`+1 cycles.
- **Pixel path latency:** 1 cycle. Outputs at cycle k+1 reflect `pixel` and the active bank as they are in cycle k.
- **Write latency:** a table write in cycle k is visible to the scan from cycle k+1.
- **Timing budget:** hblank must be at least `NUM_SPRITES`+2 cycles. The block does not check this.

## Test plan
- **Basic line:** entry 0 = x 100, y 50, tile 7. `line_start` with `next_line` 55, wait 18 cycles, then drive pixel 103 → next cycle `match` 1, `tile_number` 7, `x_offset` 3, `y_offset` 5. Pixel 116 → `match` 0, `tile_number` FFFF.
- **Priority:** entries 2 and 5 both at x 10, y 0, with tiles 0x22 and 0x55. Line 0, pixel 12 → `tile_number` 0x22.
- **Overflow:** 5 valid entries all on line 8 → `overflow` 1 after commit, only entries 0–3 matchable. A following line with 1 hit → `overflow` 0.
- **Boundaries:**
  - Entry at y 15: line 30 → hit with `y_offset` 15; line 31 → miss.
  - Entry at y FFF8: line 3 → miss.
  - Entry at x 0: pixel 15 → hit; pixel 16 → miss.
- **Abort:** second `line_start` 5 cycles into a scan → `scan_busy` stays high, the active bank is unchanged until the restarted scan commits `NUM_SPRITES`+2 cycles after the second pulse, and the result matches the second line.
- **Reset mid-scan:** assert `reset` during SCAN → `scan_busy` 0, `match` 0, all tiles FFFF. A later scan finds no hits.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// Purpose : per-scanline sprite scheduler; scans the attribute table in hblank into a
//           shadow slot bank, commits it to the active bank, resolves pixel hits.
// Latency : scan+commit NUM_SPRITES+1 cycles after line_start; pixel path 1 cycle.
// Backpressure: none; hblank must last at least NUM_SPRITES+2 cycles (not checked).
//
// Ports:
//   gpu_clk, reset          sole clock, async active-high reset
//   cfg_we/index/field/wdata attribute table write (field 0 = {y,x}, 1 = tile in [31:16])
//   line_start, next_line   hblank pulse and the line to schedule
//   pixel                   current pixel x
//   scan_busy, overflow     scan in progress / more than NUM_SLOTS hits on committed line
//   match, tile_number, x_offset, y_offset   registered per-pixel resolve result
module sprite_line_scheduler #(
  parameter int NUM_SPRITES = 16,
  parameter int NUM_SLOTS   = 4,
  parameter int IDX_W       = 4
) (
  input  logic             gpu_clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_index,
  input  logic             cfg_field,
  input  logic [31:0]      cfg_wdata,
  input  logic             line_start,
  input  logic [15:0]      next_line,
  input  logic [15:0]      pixel,
  output logic             scan_busy,
  output logic             overflow,
  output logic             match,
  output logic [15:0]      tile_number,
  output logic [7:0]       x_offset,
  output logic [7:0]       y_offset
);

  localparam int FILL_W = $clog2(NUM_SLOTS + 1);
  localparam logic [15:0] NO_TILE = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t state, state_nxt;

  // attribute table
  logic [15:0] tbl_x    [NUM_SPRITES];
  logic [15:0] tbl_y    [NUM_SPRITES];
  logic [15:0] tbl_tile [NUM_SPRITES];

  // scan context
  logic [15:0]      line_q;
  logic [IDX_W-1:0] scan_idx;
  logic [FILL_W-1:0] fill;
  logic             ovf_flag;

  // shadow and active slot banks
  logic [NUM_SLOTS-1:0] sh_vld;
  logic [15:0]          sh_x    [NUM_SLOTS];
  logic [15:0]          sh_tile [NUM_SLOTS];
  logic [3:0]           sh_yoff [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] act_vld;
  logic [15:0]          act_x    [NUM_SLOTS];
  logic [15:0]          act_tile [NUM_SLOTS];
  logic [3:0]           act_yoff [NUM_SLOTS];

  // FSM control strobes
  logic start_scan, step_scan, do_commit;

  // ---------------------------------------------------------------------------
  // Attribute table. The scan reads the registered contents, so a write landing
  // on the entry being scanned this cycle is not seen until the next line.
  // ---------------------------------------------------------------------------
  always_ff @(posedge gpu_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        tbl_x[i]    <= '0;
        tbl_y[i]    <= '0;
        tbl_tile[i] <= NO_TILE;
      end
    end else if (cfg_we) begin
      if (cfg_field) begin
        tbl_tile[cfg_index] <= cfg_wdata[31:16];
      end else begin
        tbl_x[cfg_index] <= cfg_wdata[15:0];
        tbl_y[cfg_index] <= cfg_wdata[31:16];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge gpu_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    start_scan = 1'b0;
    step_scan  = 1'b0;
    do_commit  = 1'b0;
    // line_start wins in every state: an in-flight scan or commit is abandoned
    if (line_start) begin
      state_nxt  = SCAN;
      start_scan = 1'b1;
    end else begin
      case (state)
        SCAN: begin
          step_scan = 1'b1;
          if (scan_idx == IDX_W'(NUM_SPRITES - 1)) state_nxt = COMMIT;
        end
        COMMIT: begin
          do_commit = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry hit test: 17-bit compare so entries near 16'hFFFF do not wrap to line 0
  // ---------------------------------------------------------------------------
  logic [16:0] ent_y17, line17;
  logic [15:0] ent_dy;
  logic        ent_hit;

  always_comb begin
    ent_y17 = {1'b0, tbl_y[scan_idx]};
    line17  = {1'b0, line_q};
    ent_dy  = line_q - tbl_y[scan_idx];
    ent_hit = (tbl_tile[scan_idx] != NO_TILE) &&
              (ent_y17 <= line17) && (line17 < ent_y17 + 17'd16);
  end

  // ---------------------------------------------------------------------------
  // Scan datapath and bank commit
  // ---------------------------------------------------------------------------
  always_ff @(posedge gpu_clk or posedge reset) begin
    if (reset) begin
      line_q    <= '0;
      scan_idx  <= '0;
      fill      <= '0;
      ovf_flag  <= 1'b0;
      overflow  <= 1'b0;
      scan_busy <= 1'b0;
      sh_vld    <= '0;
      act_vld   <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        sh_x[s]     <= '0;
        sh_tile[s]  <= NO_TILE;
        sh_yoff[s]  <= '0;
        act_x[s]    <= '0;
        act_tile[s] <= NO_TILE;
        act_yoff[s] <= '0;
      end
    end else begin
      scan_busy <= (state_nxt != IDLE);

      if (start_scan) begin
        line_q   <= next_line;
        scan_idx <= '0;
        fill     <= '0;
        ovf_flag <= 1'b0;
        sh_vld   <= '0;
      end else if (step_scan) begin
        scan_idx <= scan_idx + IDX_W'(1);
        if (ent_hit) begin
          if (fill < FILL_W'(NUM_SLOTS)) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
              if (fill == FILL_W'(s)) begin
                sh_vld[s]  <= 1'b1;
                sh_x[s]    <= tbl_x[scan_idx];
                sh_tile[s] <= tbl_tile[scan_idx];
                sh_yoff[s] <= ent_dy[3:0];
              end
            end
            fill <= fill + FILL_W'(1);
          end else begin
            ovf_flag <= 1'b1;
          end
        end
      end

      if (do_commit) begin
        act_vld  <= sh_vld;
        overflow <= ovf_flag;
        for (int s = 0; s < NUM_SLOTS; s++) begin
          act_x[s]    <= sh_x[s];
          act_tile[s] <= sh_tile[s];
          act_yoff[s] <= sh_yoff[s];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel resolve. Slots are filled in table order, so walking from the top
  // slot down and overwriting leaves the lowest covering slot as the winner.
  // ---------------------------------------------------------------------------
  logic        win_match;
  logic [15:0] win_tile;
  logic [3:0]  win_xoff, win_yoff;
  logic [15:0] dx;

  always_comb begin
    win_match = 1'b0;
    win_tile  = NO_TILE;
    win_xoff  = '0;
    win_yoff  = '0;
    dx        = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (act_vld[s] && ({1'b0, act_x[s]} <= {1'b0, pixel}) &&
          ({1'b0, pixel} < {1'b0, act_x[s]} + 17'd16)) begin
        dx        = pixel - act_x[s];
        win_match = 1'b1;
        win_tile  = act_tile[s];
        win_xoff  = dx[3:0];
        win_yoff  = act_yoff[s];
      end
    end
  end

  always_ff @(posedge gpu_clk or posedge reset) begin
    if (reset) begin
      match       <= 1'b0;
      tile_number <= NO_TILE;
      x_offset    <= '0;
      y_offset    <= '0;
    end else begin
      match       <= win_match;
      tile_number <= win_tile;
      x_offset    <= {4'b0, win_xoff};
      y_offset    <= {4'b0, win_yoff};
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
module tb_sprite_line_scheduler;

  localparam int NS  = 16;
  localparam int NSL = 4;

  logic        gpu_clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_index;
  logic        cfg_field;
  logic [31:0] cfg_wdata;
  logic        line_start;
  logic [15:0] next_line;
  logic [15:0] pixel;
  logic        scan_busy;
  logic        overflow;
  logic        match;
  logic [15:0] tile_number;
  logic [7:0]  x_offset;
  logic [7:0]  y_offset;

  sprite_line_scheduler #(.NUM_SPRITES(NS), .NUM_SLOTS(NSL), .IDX_W(4)) dut (
    .gpu_clk(gpu_clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_index(cfg_index), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
    .line_start(line_start), .next_line(next_line), .pixel(pixel),
    .scan_busy(scan_busy), .overflow(overflow), .match(match),
    .tile_number(tile_number), .x_offset(x_offset), .y_offset(y_offset)
  );

  always #5 gpu_clk = ~gpu_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_x[NS], m_y[NS], m_tile[NS];
  int a_cnt;
  int a_x[NSL], a_tile[NSL], a_yoff[NSL];
  bit m_ovf;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_tile[i] = 'hFFFF;
    end
    a_cnt = 0;
    m_ovf = 0;
  endtask

  // the sprites on line L are the first NSL valid entries in table order whose rows cover L
  task automatic model_sched(input int L);
    a_cnt = 0;
    m_ovf = 0;
    for (int i = 0; i < NS; i++) begin
      if (m_tile[i] != 'hFFFF && m_y[i] <= L && L < m_y[i] + 16) begin
        if (a_cnt < NSL) begin
          a_x[a_cnt] = m_x[i]; a_tile[a_cnt] = m_tile[i]; a_yoff[a_cnt] = L - m_y[i];
          a_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
    end
  endtask

  task automatic model_pixel(input int p, output bit m, output int t, output int xo, output int yo);
    m = 0; t = 'hFFFF; xo = 0; yo = 0;
    for (int s = 0; s < a_cnt; s++) begin
      if (!m && a_x[s] <= p && p < a_x[s] + 16) begin
        m = 1; t = a_tile[s]; xo = p - a_x[s]; yo = a_yoff[s];
      end
    end
  endtask

  // ---------------- drive helpers ----------------
  task automatic tick();
    @(negedge gpu_clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wr(input logic [3:0] idx, input logic fld, input logic [31:0] data);
    cfg_we = 1'b1; cfg_index = idx; cfg_field = fld; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
    if (fld) m_tile[idx] = data[31:16];
    else begin m_x[idx] = data[15:0]; m_y[idx] = data[31:16]; end
  endtask

  task automatic wr_ent(input logic [3:0] idx, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] t);
    wr(idx, 1'b0, {y, x});
    wr(idx, 1'b1, {t, 16'h0});
  endtask

  // pulse line_start, count busy cycles (bounded) and leave the bench in the
  // first cycle where the new active bank is visible
  task automatic run_line(input logic [15:0] L);
    int n;
    line_start = 1'b1; next_line = L;
    tick();
    line_start = 1'b0;
    n = 0;
    while (scan_busy && n < 40) begin
      n++;
      tick();
    end
    chk("busy_len", n, NS + 1);
    model_sched(int'(L));
    chk("overflow", overflow, m_ovf);
  endtask

  typedef struct {
    logic [15:0] x, y, tile, line, pix;
    logic        m;
    logic [15:0] t;
    logic [7:0]  xo, yo;
  } vec_t;

  vec_t vt[10];

  initial begin
    bit   em;
    int   et, exo, eyo;
    logic [15:0] p;

    reset = 1'b1; cfg_we = 1'b0; cfg_index = '0; cfg_field = 1'b0; cfg_wdata = '0;
    line_start = 1'b0; next_line = '0; pixel = '0;
    model_reset();

    vt[0] = '{16'd100, 16'd50,   16'h7, 16'd55,   16'd103,   1'b1, 16'h7,    8'd3,  8'd5};
    vt[1] = '{16'd100, 16'd50,   16'h7, 16'd55,   16'd116,   1'b0, 16'hFFFF, 8'd0,  8'd0};
    vt[2] = '{16'd200, 16'd15,   16'h9, 16'd30,   16'd205,   1'b1, 16'h9,    8'd5,  8'd15};
    vt[3] = '{16'd200, 16'd15,   16'h9, 16'd31,   16'd205,   1'b0, 16'hFFFF, 8'd0,  8'd0};
    vt[4] = '{16'd0,   16'hFFF8, 16'hA, 16'd3,    16'd0,     1'b0, 16'hFFFF, 8'd0,  8'd0};
    vt[5] = '{16'd0,   16'hFFF8, 16'hA, 16'hFFFF, 16'd4,     1'b1, 16'hA,    8'd4,  8'd7};
    vt[6] = '{16'd0,   16'd0,    16'hB, 16'd0,    16'd15,    1'b1, 16'hB,    8'd15, 8'd0};
    vt[7] = '{16'd0,   16'd0,    16'hB, 16'd0,    16'd16,    1'b0, 16'hFFFF, 8'd0,  8'd0};
    vt[8] = '{16'hFFF8,16'd0,    16'hC, 16'd0,    16'd2,     1'b0, 16'hFFFF, 8'd0,  8'd0};
    vt[9] = '{16'hFFF8,16'd0,    16'hC, 16'd0,    16'hFFFF,  1'b1, 16'hC,    8'd7,  8'd0};

    // reset state
    tick();
    chk("rst_match", match, 0);
    chk("rst_tile", tile_number, 16'hFFFF);
    chk("rst_xoff", x_offset, 0);
    chk("rst_yoff", y_offset, 0);
    chk("rst_busy", scan_busy, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    tick();

    // single-entry vectors: basic line and boundary cases
    for (int v = 0; v < 10; v++) begin
      wr_ent(4'd0, vt[v].x, vt[v].y, vt[v].tile);
      run_line(vt[v].line);
      pixel = vt[v].pix;
      tick();
      chk($sformatf("vec%0d_match", v), match, vt[v].m);
      chk($sformatf("vec%0d_tile", v), tile_number, vt[v].t);
      chk($sformatf("vec%0d_xoff", v), x_offset, vt[v].xo);
      chk($sformatf("vec%0d_yoff", v), y_offset, vt[v].yo);
    end

    // priority: lower table index wins
    do_reset();
    wr_ent(4'd2, 16'd10, 16'd0, 16'h22);
    wr_ent(4'd5, 16'd10, 16'd0, 16'h55);
    run_line(16'd0);
    pixel = 16'd12; tick();
    chk("prio_match", match, 1);
    chk("prio_tile", tile_number, 16'h22);
    chk("prio_xoff", x_offset, 2);

    // overflow: five hits on line 8, only the first four scheduled
    do_reset();
    for (int i = 0; i < 5; i++) wr_ent(4'(i), 16'(i * 20), 16'd8, 16'(16'h100 + i));
    run_line(16'd8);
    chk("ovf_set", overflow, 1);
    pixel = 16'd61; tick();
    chk("ovf_e3_tile", tile_number, 16'h103);
    pixel = 16'd81; tick();
    chk("ovf_e4_dropped", match, 0);
    wr_ent(4'd5, 16'd300, 16'd40, 16'h155);
    run_line(16'd40);
    chk("ovf_clear", overflow, 0);
    pixel = 16'd305; tick();
    chk("ovf_next_tile", tile_number, 16'h155);
    chk("ovf_next_xoff", x_offset, 5);

    // abort: second line_start five cycles into a scan
    do_reset();
    wr_ent(4'd0, 16'd0, 16'd0, 16'h11);
    wr_ent(4'd1, 16'd0, 16'd100, 16'h33);
    run_line(16'd0);
    pixel = 16'd5;
    line_start = 1'b1; next_line = 16'd0; tick(); line_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_busy_before", scan_busy, 1);
    line_start = 1'b1; next_line = 16'd100; tick(); line_start = 1'b0;
    for (int c = 1; c <= NS + 1; c++) begin
      chk($sformatf("abort_busy_c%0d", c), scan_busy, 1);
      chk($sformatf("abort_old_c%0d", c), tile_number, 16'h11);
      tick();
    end
    chk("abort_busy_done", scan_busy, 0);
    chk("abort_old_last", tile_number, 16'h11);
    tick();
    chk("abort_new_tile", tile_number, 16'h33);
    chk("abort_new_match", match, 1);

    // reset in the middle of a scan
    line_start = 1'b1; next_line = 16'd0; tick(); line_start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("mrst_busy", scan_busy, 0);
    chk("mrst_match", match, 0);
    chk("mrst_tile", tile_number, 16'hFFFF);
    tick();
    reset = 1'b0;
    model_reset();
    run_line(16'd0);
    pixel = 16'd5; tick();
    chk("mrst_line0_miss", match, 0);
    run_line(16'd100);
    tick();
    chk("mrst_line100_miss", match, 0);

    // config writes racing the scan
    do_reset();
    wr(4'd3, 1'b0, {16'd0, 16'd60});
    wr(4'd10, 1'b0, {16'd0, 16'd30});
    line_start = 1'b1; next_line = 16'd0; tick(); line_start = 1'b0;
    tick(); tick(); tick();
    cfg_we = 1'b1; cfg_index = 4'd3; cfg_field = 1'b1; cfg_wdata = {16'h44, 16'h0};
    tick();
    cfg_index = 4'd10; cfg_wdata = {16'hAA, 16'h0};
    tick();
    cfg_we = 1'b0;
    for (int n = 0; n < 40 && scan_busy; n++) tick();
    chk("race_done", scan_busy, 0);
    pixel = 16'd31; tick();
    chk("race_later_seen", tile_number, 16'hAA);
    pixel = 16'd61; tick();
    chk("race_same_cycle_unseen", match, 0);

    // randomized traffic against the reference model
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int nw;
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        logic [15:0] t;
        t = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 255));
        wr_ent(4'($urandom_range(0, 15)), 16'($urandom_range(0, 99)),
               16'($urandom_range(0, 40)), t);
      end
      run_line(16'($urandom_range(0, 50)));
      for (int k = 0; k < 6; k++) begin
        p = 16'($urandom_range(0, 120));
        pixel = p;
        tick();
        model_pixel(int'(p), em, et, exo, eyo);
        chk($sformatf("rnd%0d_match", it), match, em);
        chk($sformatf("rnd%0d_tile", it), tile_number, et);
        chk($sformatf("rnd%0d_xoff", it), x_offset, exo);
        chk($sformatf("rnd%0d_yoff", it), y_offset, eyo);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
